// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO result registers.
// An accepted mult/div is latched and held for a fixed number of busy cycles.
// The result is computed in one shot from the latched operands and written
// on the terminal-count edge. A down-counter times the busy window.
//
// state | meaning
// IDLE  | accepting commands; mthi/mtlo write immediately
// RUN   | arithmetic op in flight; Busy high; all Start strobes ignored
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             DivZero
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_TC = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   q_res;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_dz;

    // Products from the latched operands; sign-extended to full width for the signed case
    assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed division via magnitudes so most-negative / -1 wraps to most-negative
    // without relying on tool behaviour for signed overflow; divisor forced
    // non-zero so the divider never sees zero.
    always_comb begin
        a_neg  = (op_q == OP_DIV) & a_q[WIDTH-1];
        b_neg  = (op_q == OP_DIV) & b_q[WIDTH-1];
        a_mag  = a_neg ? -a_q : a_q;
        b_mag  = b_neg ? -b_q : b_q;
        b_safe = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        q_res  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r_res  = a_neg ? -r_mag : r_mag;
    end

    // Select the result written at terminal count
    always_comb begin
        res_hi = HI;
        res_lo = LO;
        res_dz = 1'b0;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (b_q == '0) begin
                    res_hi = a_q;
                    res_lo = '1;
                    res_dz = 1'b1;
                end else begin
                    res_hi = r_res;
                    res_lo = q_res;
                end
            end
            default: ;
        endcase
    end

    // Control FSM, busy timer and HI/LO/DivZero registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            HI      <= '0;
            LO      <= '0;
            Busy    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                op_q  <= Op;
                                a_q   <= A;
                                b_q   <= B;
                                cnt   <= (Op == OP_MULT || Op == OP_MULTU) ? MULT_N : DIV_N;
                                state <= RUN;
                                Busy  <= 1'b1;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_TC;
                    if (cnt == CNT_TC) begin
                        HI      <= res_hi;
                        LO      <= res_lo;
                        DivZero <= res_dz;
                        state   <= IDLE;
                        Busy    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/HI/LO width in bits (>=8).
REQ-002 SHALL provide parameter MULT_CYCLES, default 5, Busy cycles for mult/multu (>=1).
REQ-003 SHALL provide parameter DIV_CYCLES, default 10, Busy cycles for div/divu (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  command strobe, sampled each rising edge.
REQ-007 Op  input  3  command: 000 nop, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 nop.
REQ-008 A  input  WIDTH  operand 1 (multiplicand/dividend/move source).
REQ-009 B  input  WIDTH  operand 2 (multiplier/divisor).
REQ-010 HI  output  WIDTH  high product / remainder register.
REQ-011 LO  output  WIDTH  low product / quotient register.
REQ-012 Busy  output  1  high while an arithmetic operation is in progress.
REQ-013 DivZero  output  1  sticky flag, set by div/divu with B==0, cleared by next accepted mult/div.

Function
REQ-014 SHALL implement FSM states IDLE and RUN; Busy==1 exactly in RUN.
REQ-015 IDLE, Start==1, Op in {001..100}: latch A, B, Op; load counter with MULT_CYCLES or DIV_CYCLES; go RUN next edge.
REQ-016 RUN: decrement counter each edge; on edge where counter==1 write HI/LO and return to IDLE.
REQ-017 Latency: Start accepted at edge t -> Busy=1 for cycles t+1..t+N, Busy=0 and new HI/LO visible from t+N+1 (N = MULT_CYCLES or DIV_CYCLES).
REQ-018 HI/LO SHALL hold previous values throughout RUN; no partial results visible.
REQ-019 Start while Busy==1 (any Op, including mthi/mtlo) SHALL be ignored entirely; A/B changes during RUN SHALL not affect result.
REQ-020 mthi/mtlo with Start in IDLE: HI (resp. LO) <= A at that edge, other register unchanged, Busy stays 0.
REQ-021 Op 000/111 or Start==0: no state change.
REQ-022 mult: signed 2*WIDTH product; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-023 multu: same split, unsigned operands.
REQ-024 div: signed, quotient truncates toward zero -> LO; remainder carries dividend sign -> HI.
REQ-025 div with A = most-negative, B = -1: LO = most-negative, HI = 0, no flag.
REQ-026 divu: unsigned quotient -> LO, remainder -> HI.
REQ-027 Division with B==0: LO = all ones, HI = A, DivZero=1, full DIV_CYCLES latency still applies.
REQ-028 DivZero SHALL update at the same edge as HI/LO; mthi/mtlo leave it unchanged.
REQ-029 Implementation technique (iterative or single-shot compute plus counter) is free provided REQ-017 timing holds exactly.

Reset
REQ-030 reset==1 at an edge: state IDLE, HI=0, LO=0, Busy=0, DivZero=0, counter=0, regardless of Start/Op.
REQ-031 reset during RUN SHALL abort the operation; no HI/LO write after reset deasserts.
REQ-032 reset has priority over Start on the same edge.

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
REQ-033 multu A=0xFFFFFFFF B=2 -> Busy high 5 cycles, then HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 mult A=0xFFFFFFFD(-3) B=5 -> after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; div A=0xFFFFFFF9(-7) B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 divu A=0x1234 B=0 -> after 10 cycles LO=0xFFFFFFFF, HI=0x00001234, DivZero=1; next mult clears DivZero at its completion.
REQ-036 Start mult 3*4, then Start mtlo A=0x55 and Start divu on cycles 2 and 3 of Busy -> both ignored; final HI=0, LO=0x0000000C.
REQ-037 mthi A=0xAAAA0000 then mtlo A=0x5555 in IDLE -> HI=0xAAAA0000, LO=0x00005555 one cycle each, Busy=0.
REQ-038 Start div, assert reset on Busy cycle 4 -> HI=LO=0, Busy=0 next cycle, no later HI/LO change.
